// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller in front of a synchronous-write, combinational-read memory.
// Accepts one read/write at a time, holds the read enable LATENCY cycles, then presents one response.
module mem_req_ctrl #(
  parameter int N       = 1024,
  parameter int M       = 32,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [$clog2(N)-1:0] req_addr,
  input  logic [M-1:0]         req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [M-1:0]         resp_rdata,
  output logic                 resp_err,
  output logic                 mem_write_enable,
  output logic                 mem_read_enable,
  output logic [$clog2(N)-1:0] mem_write_addr,
  output logic [$clog2(N)-1:0] mem_read_addr,
  output logic [M-1:0]         mem_write_data,
  input  logic [M-1:0]         mem_read_data,
  output logic [1:0]           dbg_state
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign dbg_state = state;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The request side is ready only in IDLE; the response stays valid and stable until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_addr   <= '0;
      mem_read_addr    <= '0;
      mem_write_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (32'(req_addr) >= N) begin
              // Out-of-range requests never touch the memory.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we) begin
              state            <= WRITE;
              mem_write_enable <= 1'b1;
              mem_write_addr   <= req_addr;
              mem_write_data   <= req_wdata;
            end else begin
              state           <= READ;
              mem_read_enable <= 1'b1;
              mem_read_addr   <= req_addr;
              cnt             <= CW'(LATENCY - 1);
            end
          end
        end
        WRITE: begin
          state            <= RESP;
          mem_write_enable <= 1'b0;
          mem_write_addr   <= '0;
          mem_write_data   <= '0;
          resp_valid       <= 1'b1;
        end
        READ: begin
          if (cnt == '0) begin
            state           <= RESP;
            resp_rdata      <= mem_read_data;
            resp_valid      <= 1'b1;
            mem_read_enable <= 1'b0;
            mem_read_addr   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: three instances (LATENCY 2, 1, 4; N=1000) each with its own memory,
// checked against a reference memory and a transaction-level timing model.
module tb_mem_req_ctrl;

  localparam int NN = 1000;
  localparam int MW = 32;
  localparam int AW = 10;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;

  logic [ND-1:0]         req_valid, req_ready, req_we;
  logic [ND-1:0][AW-1:0] req_addr;
  logic [ND-1:0][MW-1:0] req_wdata;
  logic [ND-1:0]         resp_valid, resp_ready, resp_err;
  logic [ND-1:0][MW-1:0] resp_rdata;
  logic [ND-1:0]         mwe, mre;
  logic [ND-1:0][AW-1:0] mwa, mra;
  logic [ND-1:0][MW-1:0] mwd, mrd;
  logic [ND-1:0][1:0]    dbg;

  logic [MW-1:0] ref_mem [ND][1024];
  logic [MW-1:0] salt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [MW-1:0] init_val(input int g, input int i);
    return salt ^ (32'(g) << 28) ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [MW-1:0] mem [1024];

    mem_req_ctrl #(.N(NN), .M(MW), .LATENCY(L)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid[g]),
      .req_ready        (req_ready[g]),
      .req_we           (req_we[g]),
      .req_addr         (req_addr[g]),
      .req_wdata        (req_wdata[g]),
      .resp_valid       (resp_valid[g]),
      .resp_ready       (resp_ready[g]),
      .resp_rdata       (resp_rdata[g]),
      .resp_err         (resp_err[g]),
      .mem_write_enable (mwe[g]),
      .mem_read_enable  (mre[g]),
      .mem_write_addr   (mwa[g]),
      .mem_read_addr    (mra[g]),
      .mem_write_data   (mwd[g]),
      .mem_read_data    (mrd[g]),
      .dbg_state        (dbg[g])
    );

    assign mrd[g] = mem[mra[g]];

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_val(g, i);
      end else if (mwe[g]) begin
        mem[mwa[g]] <= mwd[g];
      end
    end
  end

  // Drives one request from a negedge in IDLE and observes until the response appears.
  // Returns at the response cycle's negedge (or one cycle later, back in IDLE, if resp_ready is 1).
  task automatic run_txn(input int g, input bit we, input logic [AW-1:0] addr,
                         input logic [MW-1:0] wd, output int lat, output int re_n,
                         output int we_n, output bit side_ok, output logic [MW-1:0] rd,
                         output logic er);
    lat = 0; re_n = 0; we_n = 0; side_ok = 1'b1; rd = 'x; er = 1'bx;
    req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = addr; req_wdata[g] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (mre[g]) begin
        re_n++;
        if (mra[g] !== addr) side_ok = 1'b0;
      end else if (mra[g] !== '0) side_ok = 1'b0;
      if (mwe[g]) begin
        we_n++;
        if (mwa[g] !== addr || mwd[g] !== wd) side_ok = 1'b0;
      end else if (mwa[g] !== '0 || mwd[g] !== '0) side_ok = 1'b0;
      if (resp_valid[g]) begin
        lat = k; rd = resp_rdata[g]; er = resp_err[g];
      end
    end
    if (resp_ready[g]) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int g = 0; g < ND; g++) begin
      checks++;
      if (req_ready[g] !== 1'b1) begin
        failures++; $display("FAIL reset_req_ready g=%0d got=%b exp=1", g, req_ready[g]);
      end
      checks++;
      if (resp_valid[g] !== 1'b0) begin
        failures++; $display("FAIL reset_resp_valid g=%0d got=%b exp=0", g, resp_valid[g]);
      end
      checks++;
      if ({resp_rdata[g], resp_err[g], mwe[g], mre[g], mwa[g], mra[g], mwd[g]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs g=%0d got rdata=%h err=%b we=%b re=%b wa=%h ra=%h wd=%h exp=all zero",
                 g, resp_rdata[g], resp_err[g], mwe[g], mre[g], mwa[g], mra[g], mwd[g]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er;
    run_txn(0, 1'b1, 10'd5, 32'hDEAD_BEEF, lat, re_n, we_n, ok, rd, er);
    ref_mem[0][5] = 32'hDEAD_BEEF;
    checks++;
    if (lat !== 2 || we_n !== 1 || re_n !== 0 || !ok) begin
      failures++;
      $display("FAIL write5 got lat=%0d we_cycles=%0d re_cycles=%0d side_ok=%0b exp lat=2 we=1 re=0 ok=1",
               lat, we_n, re_n, ok);
    end
    checks++;
    if (rd !== '0 || er !== 1'b0) begin
      failures++; $display("FAIL write5_resp got rdata=%h err=%b exp rdata=0 err=0", rd, er);
    end
    run_txn(0, 1'b0, 10'd5, '0, lat, re_n, we_n, ok, rd, er);
    checks++;
    if (lat !== 3 || re_n !== 2 || we_n !== 0 || !ok) begin
      failures++;
      $display("FAIL read5 got lat=%0d re_cycles=%0d we_cycles=%0d side_ok=%0b exp lat=3 re=2 we=0 ok=1",
               lat, re_n, we_n, ok);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      failures++; $display("FAIL read5_resp got rdata=%h err=%b exp rdata=deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_read_latency();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er; logic [AW-1:0] a;
    for (int g = 1; g < ND; g++) begin
      a = AW'($urandom_range(0, NN - 1));
      run_txn(g, 1'b0, a, '0, lat, re_n, we_n, ok, rd, er);
      checks++;
      if (lat !== lat_of(g) + 1 || re_n !== lat_of(g) || !ok) begin
        failures++;
        $display("FAIL read_latency g=%0d got lat=%0d re_cycles=%0d side_ok=%0b exp lat=%0d re=%0d ok=1",
                 g, lat, re_n, ok, lat_of(g) + 1, lat_of(g));
      end
      checks++;
      if (rd !== ref_mem[g][a] || er !== 1'b0) begin
        failures++;
        $display("FAIL read_latency_data g=%0d got rdata=%h err=%b exp rdata=%h err=0",
                 g, rd, er, ref_mem[g][a]);
      end
    end
  endtask

  task automatic test_error();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er; logic [AW-1:0] a; bit we;
    for (int g = 0; g < ND; g++) begin
      a  = (g == 0) ? AW'(NN) : AW'($urandom_range(NN, 1023));
      we = (g == 2);
      run_txn(g, we, a, $urandom, lat, re_n, we_n, ok, rd, er);
      checks++;
      if (lat !== 1 || re_n !== 0 || we_n !== 0 || !ok) begin
        failures++;
        $display("FAIL error_timing g=%0d addr=%0d got lat=%0d re=%0d we=%0d ok=%0b exp lat=1 re=0 we=0 ok=1",
                 g, a, lat, re_n, we_n, ok);
      end
      checks++;
      if (er !== 1'b1 || rd !== '0) begin
        failures++;
        $display("FAIL error_resp g=%0d got err=%b rdata=%h exp err=1 rdata=0", g, er, rd);
      end
    end
  endtask

  task automatic test_random();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er;
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] wd, exp_rd;
    logic [AW-1:0] a;
    int g, exp_lat, exp_re, exp_we;
    bit we, bad;
    for (int t = 0; t < 30; t++) begin
      g  = $urandom_range(0, ND - 1);
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(NN, 1023))
                                       : AW'($urandom_range(0, 15));
      wd = $urandom;
      bad     = (int'(a) >= NN);
      exp_lat = bad ? 1 : (we ? 2 : lat_of(g) + 1);
      exp_re  = (!bad && !we) ? lat_of(g) : 0;
      exp_we  = (!bad && we) ? 1 : 0;
      exp_q.push_back((bad || we) ? '0 : ref_mem[g][a]);
      if (!bad && we) ref_mem[g][a] = wd;
      run_txn(g, we, a, wd, lat, re_n, we_n, ok, rd, er);
      exp_rd = exp_q.pop_front();
      checks++;
      if (lat !== exp_lat || re_n !== exp_re || we_n !== exp_we || !ok) begin
        failures++;
        $display("FAIL random_timing t=%0d g=%0d we=%0b addr=%0d got lat=%0d re=%0d we=%0d ok=%0b exp lat=%0d re=%0d we=%0d ok=1",
                 t, g, we, a, lat, re_n, we_n, ok, exp_lat, exp_re, exp_we);
      end
      checks++;
      if (rd !== exp_rd || er !== bad) begin
        failures++;
        $display("FAIL random_resp t=%0d g=%0d got rdata=%h err=%b exp rdata=%h err=%b",
                 t, g, rd, er, exp_rd, bad);
      end
    end
  endtask

  task automatic test_resp_hold();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er;
    logic [AW-1:0] a, other;
    bit stable;
    a     = AW'($urandom_range(0, 499));
    other = AW'($urandom_range(500, NN - 1));
    resp_ready[0] = 1'b0;
    run_txn(0, 1'b0, a, '0, lat, re_n, we_n, ok, rd, er);
    checks++;
    if (lat !== 3 || rd !== ref_mem[0][a]) begin
      failures++;
      $display("FAIL hold_first got lat=%0d rdata=%h exp lat=3 rdata=%h", lat, rd, ref_mem[0][a]);
    end
    stable = 1'b1;
    for (int h = 0; h < 5; h++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = other; req_wdata[0] = ~ref_mem[0][other];
      @(negedge clk);
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== ref_mem[0][a] || resp_err[0] !== 1'b0 ||
          req_ready[0] !== 1'b0 || mwe[0] !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++; $display("FAIL hold_stable got stable=0 exp stable=1");
    end
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got resp_valid=%b req_ready=%b exp 0 1", resp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (mwe[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_ignored got mem_we=%b req_ready=%b exp 0 1", mwe[0], req_ready[0]);
    end
    run_txn(0, 1'b0, other, '0, lat, re_n, we_n, ok, rd, er);
    checks++;
    if (rd !== ref_mem[0][other]) begin
      failures++;
      $display("FAIL hold_not_written got rdata=%h exp %h", rd, ref_mem[0][other]);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, re_n, we_n; bit ok; logic [MW-1:0] rd; logic er; logic [AW-1:0] a;
    a = AW'($urandom_range(0, NN - 1));
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = a;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mre[0] !== 1'b0 || mra[0] !== '0 || req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got re=%b ra=%h req_ready=%b resp_valid=%b exp 0 0 1 0",
               mre[0], mra[0], req_ready[0], resp_valid[0]);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 1'b0, a, '0, lat, re_n, we_n, ok, rd, er);
    checks++;
    if (lat !== 3 || re_n !== 2 || rd !== ref_mem[0][a]) begin
      failures++;
      $display("FAIL reset_recover got lat=%0d re=%0d rdata=%h exp lat=3 re=2 rdata=%h",
               lat, re_n, rd, ref_mem[0][a]);
    end
  endtask

  task automatic test_back_to_back(input int g);
    logic [MW-1:0] exp_q[$];
    int iss_q[$];
    logic [MW-1:0] exp_v;
    logic [AW-1:0] a;
    int c0, cyc, issued, got, last_resp, l;
    l = lat_of(g); cyc = 0; issued = 0; got = 0; last_resp = -1;
    resp_ready[g] = 1'b1;
    req_we[g] = 1'b0;
    while (got < 4 && cyc < 100) begin
      if (resp_valid[g]) begin
        exp_v = exp_q.pop_front();
        c0    = iss_q.pop_front();
        checks++;
        if (resp_rdata[g] !== exp_v) begin
          failures++;
          $display("FAIL b2b_data g=%0d n=%0d got %h exp %h", g, got, resp_rdata[g], exp_v);
        end
        checks++;
        if (cyc - c0 !== l + 1) begin
          failures++;
          $display("FAIL b2b_latency g=%0d n=%0d got %0d exp %0d", g, got, cyc - c0, l + 1);
        end
        got++;
        last_resp = cyc;
      end
      if (req_ready[g]) begin
        if (issued > 0) begin
          checks++;
          if (cyc - last_resp !== 1) begin
            failures++;
            $display("FAIL b2b_gap g=%0d got %0d exp 1", g, cyc - last_resp);
          end
        end
        if (issued < 4) begin
          a = AW'($urandom_range(0, NN - 1));
          req_valid[g] = 1'b1; req_addr[g] = a;
          exp_q.push_back(ref_mem[g][a]);
          iss_q.push_back(cyc);
          issued++;
        end else begin
          req_valid[g] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid[g] = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++; $display("FAIL b2b_count g=%0d got %0d exp 4", g, got);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got timeout exp completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    for (int g = 0; g < ND; g++)
      for (int i = 0; i < 1024; i++) ref_mem[g][i] = init_val(g, i);
    rst        = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_write_read();
    test_read_latency();
    test_error();
    test_random();
    test_resp_hold();
    test_reset_mid_read();
    test_back_to_back(0);
    test_back_to_back(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 1024, memory depth in words.
REQ-002 The block SHALL have parameter M, default 32, data width in bits.
REQ-003 The block SHALL have parameter LATENCY, default 2, read hold cycles; legal range >=1.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-008 The block SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, $clog2(N), word address.
REQ-010 The block SHALL have port req_wdata, input, M, write data.
REQ-011 The block SHALL have port resp_valid, output, 1, response present.
REQ-012 The block SHALL have port resp_ready, input, 1, consumer accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, M, read data (0 for writes and errors).
REQ-014 The block SHALL have port resp_err, output, 1, request address was >= N.
REQ-015 The block SHALL have memory-side outputs mem_write_enable (1), mem_read_enable (1), mem_write_addr ($clog2(N)), mem_read_addr ($clog2(N)) and mem_write_data (M).
REQ-016 The block SHALL have memory-side input mem_read_data (M), combinational read data from the memory.

Function
REQ-017 The block SHALL implement FSM states IDLE, WRITE, READ, RESP, with all outputs driven from registers.
REQ-018 IDLE SHALL assert req_ready=1; every other state SHALL hold req_ready=0.
REQ-019 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; we/addr/wdata SHALL be latched at that edge (T0).
REQ-020 An accepted request with req_addr>=N SHALL go directly to RESP with resp_err=1 and resp_rdata=0; no mem enable SHALL assert.
REQ-021 An accepted in-range write SHALL enter WRITE, asserting mem_write_enable=1 with the latched addr/data for exactly the one cycle after T0, then enter RESP.
REQ-022 An in-range read SHALL enter READ, holding mem_read_enable=1 and a stable mem_read_addr for exactly LATENCY cycles (T0+1..T0+LATENCY), counted by a down-counter loaded with LATENCY-1.
REQ-023 At the edge ending the last READ cycle, mem_read_data SHALL be captured into resp_rdata and the FSM SHALL enter RESP.
REQ-024 RESP SHALL hold resp_valid=1 and stable resp_rdata/resp_err until an edge with resp_ready=1, then return to IDLE.
REQ-025 Response timing with resp_ready=1 SHALL be: write resp_valid high in cycle T0+2; read resp_valid high in cycle T0+LATENCY+1; error resp_valid high in cycle T0+1.
REQ-026 Outside WRITE, mem_write_enable SHALL be 0 and mem_write_addr/mem_write_data SHALL be 0; outside READ, mem_read_enable SHALL be 0 and mem_read_addr SHALL be 0.
REQ-027 A write followed by a read to the same address SHALL return the written data, because the write commits before the read phase begins.
REQ-028 req_valid asserted while req_ready=0 SHALL be ignored and not latched.
REQ-029 The block SHALL support at most one outstanding request; the next request SHALL not be accepted before the cycle after response acceptance.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 and all mem_* outputs 0.
REQ-031 Reset during WRITE, READ or RESP SHALL discard the in-flight request with no response; mem enables SHALL drop in the same cycle.
REQ-032 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-033 Write 0xDEADBEEF to addr 5, then read addr 5 (LATENCY=2) -> mem_write_enable one cycle; read resp_valid at T0+3 with rdata 0xDEADBEEF, resp_err=0.
REQ-034 Read with LATENCY=1 and LATENCY=4 -> mem_read_enable high for exactly 1 and 4 cycles, address stable, resp_valid at T0+2 and T0+5.
REQ-035 N=1000, read addr 1000 -> no mem enable, resp_valid at T0+1, resp_err=1, rdata=0.
REQ-036 Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and rdata stable, req_ready=0, and a concurrent req_valid is not accepted.
REQ-037 Assert rst mid-READ (cycle T0+1) -> mem_read_enable=0 asynchronously, no resp_valid afterwards, req_ready=1 after release.
REQ-038 Back-to-back reads with req_valid held high -> next request accepted on the edge after response acceptance; mem_read_data values match per request.
